// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver, LSB first, 2-flop input synchronizer, mid-bit sampling.
// Optional macro SERIAL_RX_FRAME_ERR_EN: a bad stop bit pulses frame_err instead of delivering the byte.
module serial_rx #(
   parameter int CLK_PER_BIT = 27,
   parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       new_data,
   output logic       busy,
   output logic       frame_err
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START_BIT = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP_BIT  = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   localparam logic [CTR_SIZE-1:0] CTR_MID  = CTR_SIZE'((CLK_PER_BIT - 1) / 2);
   localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
   localparam logic [CTR_SIZE-1:0] CTR_ONE  = CTR_SIZE'(1);

   logic                rx_meta_q, rx_s_q;
   logic [2:0]          state_q, state_d;
   logic [CTR_SIZE-1:0] ctr_q, ctr_d;
   logic [2:0]          bit_ctr_q, bit_ctr_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          data_q, data_d;
   logic                new_data_q, new_data_d;
   logic                busy_q, busy_d;
   logic                frame_err_q, frame_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= IDLE;
         ctr_q       <= '0;
         bit_ctr_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         new_data_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         bit_ctr_q   <= bit_ctr_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         new_data_q  <= new_data_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Frame FSM: ctr times the bit period, bit_ctr indexes the data bit being captured.
   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      bit_ctr_d   = bit_ctr_q;
      shift_d     = shift_q;
      data_d      = data_q;
      new_data_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            ctr_d     = '0;
            bit_ctr_d = '0;
            if (!rx_s_q) state_d = START_BIT;
         end
         START_BIT: begin
            if (ctr_q == CTR_MID) begin
               ctr_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               ctr_d = ctr_q + CTR_ONE;
            end
         end
         DATA: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d              = '0;
               shift_d[bit_ctr_q] = rx_s_q;
               bit_ctr_d          = bit_ctr_q + 3'd1;
               if (bit_ctr_q == 3'd7) state_d = STOP_BIT;
            end else begin
               ctr_d = ctr_q + CTR_ONE;
            end
         end
         STOP_BIT: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d = '0;
               if (rx_s_q) begin
                  data_d     = shift_q;
                  new_data_d = 1'b1;
                  state_d    = IDLE;
               end else begin
`ifdef SERIAL_RX_FRAME_ERR_EN
                  frame_err_d = 1'b1;
`else
                  data_d     = shift_q;
                  new_data_d = 1'b1;
`endif
                  state_d = WAIT_HIGH;
               end
            end else begin
               ctr_d = ctr_q + CTR_ONE;
            end
         end
         WAIT_HIGH: begin
            // A held-low break must not look like a new start bit.
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign new_data  = new_data_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule
